// File: rtl/countdown_chain_timer.sv
// Loadable cascaded modulo-(STAGE_MAX+1) down-counter chain with a prescaled
// decrement tick and a start/pause/done control FSM.
//
//   state  | meaning
//   IDLE   | loaded or reset; waits for start
//   RUN    | prescaler counting, chain decrements on each prescaler wrap
//   PAUSED | prescaler and chain frozen; start resumes without reload
//   DONE   | chain reached zero; only load or reset leaves
module countdown_chain_timer #(
  parameter int STAGE_WIDTH = 4,
  parameter int NUM_STAGES  = 4,
  parameter int STAGE_MAX   = 9,
  parameter int PRESCALE    = 50000000
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              load,
  input  logic [STAGE_WIDTH*NUM_STAGES-1:0] load_value,
  input  logic                              start,
  input  logic                              pause,
  output logic [STAGE_WIDTH*NUM_STAGES-1:0] count,
  output logic                              tick,
  output logic                              running,
  output logic                              done
);

  localparam int CW = STAGE_WIDTH * NUM_STAGES;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]          PRESC_RELOAD = PW'(PRESCALE - 1);
  localparam logic [STAGE_WIDTH-1:0] SMAX         = STAGE_WIDTH'(STAGE_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state, next_state;
  logic [PW-1:0] presc, next_presc;
  logic [CW-1:0] next_count;
  logic [CW-1:0] load_clamped;
  logic [CW-1:0] dec_count;
  logic          next_tick;
  logic          next_done;
  logic          borrow;
  logic          count_zero;
  logic          dec_zero;

  always_comb begin
    load_clamped = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (load_value[k*STAGE_WIDTH +: STAGE_WIDTH] > SMAX)
        load_clamped[k*STAGE_WIDTH +: STAGE_WIDTH] = SMAX;
      else
        load_clamped[k*STAGE_WIDTH +: STAGE_WIDTH] = load_value[k*STAGE_WIDTH +: STAGE_WIDTH];
    end
  end

  // Stage k steps only while every lower stage reads zero (borrow chain).
  always_comb begin
    dec_count = count;
    borrow    = 1'b1;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (borrow) begin
        if (count[k*STAGE_WIDTH +: STAGE_WIDTH] == '0)
          dec_count[k*STAGE_WIDTH +: STAGE_WIDTH] = SMAX;
        else
          dec_count[k*STAGE_WIDTH +: STAGE_WIDTH] =
            count[k*STAGE_WIDTH +: STAGE_WIDTH] - STAGE_WIDTH'(1);
      end
      borrow = borrow & (count[k*STAGE_WIDTH +: STAGE_WIDTH] == '0);
    end
  end

  assign count_zero = (count == '0);
  assign dec_zero   = (dec_count == '0);

  always_comb begin
    next_state = state;
    next_count = count;
    next_presc = presc;
    next_tick  = 1'b0;
    next_done  = 1'b0;
    if (load) begin
      next_state = IDLE;
      next_count = load_clamped;
      next_presc = PRESC_RELOAD;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (count_zero) begin
              next_state = DONE;
              next_done  = 1'b1;
            end else begin
              next_state = RUN;
              next_presc = PRESC_RELOAD;
            end
          end
        end
        RUN: begin
          if (pause) begin
            next_state = PAUSED;
          end else if (presc == '0) begin
            next_presc = PRESC_RELOAD;
            next_count = dec_count;
            next_tick  = 1'b1;
            if (dec_zero) begin
              next_state = DONE;
              next_done  = 1'b1;
            end
          end else begin
            next_presc = presc - PW'(1);
          end
        end
        PAUSED: begin
          if (start && !pause) next_state = RUN;
        end
        DONE: begin
          next_state = DONE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      presc   <= PRESC_RELOAD;
      tick    <= 1'b0;
      done    <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= next_state;
      count   <= next_count;
      presc   <= next_presc;
      tick    <= next_tick;
      done    <= next_done;
      running <= (next_state == RUN);
    end
  end

endmodule

// File: tb/tb_countdown_chain_timer.sv
// Directed bench for countdown_chain_timer with PRESCALE=4; expected values
// are hand-derived cycle by cycle from the decrement and FSM rules.
module tb_countdown_chain_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] load_value;
  logic        start;
  logic        pause;
  logic [15:0] count;
  logic        tick;
  logic        running;
  logic        done;

  int checks   = 0;
  int failures = 0;

  countdown_chain_timer #(
    .STAGE_WIDTH(4),
    .NUM_STAGES (4),
    .STAGE_MAX  (9),
    .PRESCALE   (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_value(load_value),
    .start     (start),
    .pause     (pause),
    .count     (count),
    .tick      (tick),
    .running   (running),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    load_value = v;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; load = 1'b0; load_value = '0; start = 1'b1; pause = 1'b0;

    // Reset with start held
    step(); step();
    chk("rst_count", count, 16'h0000);
    chk("rst_running", running, 1'b0);
    chk("rst_tick", tick, 1'b0);
    chk("rst_done", done, 1'b0);
    reset = 1'b0; start = 1'b0;
    step(); step(); step();
    chk("idle_running", running, 1'b0);
    chk("idle_done", done, 1'b0);

    // Borrow across stages
    do_load(16'h0102);
    chk("ld0102_count", count, 16'h0102);
    chk("ld0102_running", running, 1'b0);
    do_start();
    chk("borrow_running", running, 1'b1);
    chk("borrow_count0", count, 16'h0102);
    begin
      logic [15:0] seq [4];
      logic [15:0] prev;
      seq[0] = 16'h0101; seq[1] = 16'h0100; seq[2] = 16'h0099; seq[3] = 16'h0098;
      prev = 16'h0102;
      for (int s = 0; s < 4; s++) begin
        for (int i = 1; i <= 4; i++) begin
          step();
          chk("borrow_tick", tick, (i == 4));
          chk("borrow_count", count, (i == 4) ? seq[s] : prev);
        end
        prev = seq[s];
      end
    end

    // Terminal count
    do_load(16'h0002);
    do_start();
    chk("term_running", running, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 4) chk("term_count1", count, 16'h0001);
      chk("term_tick", tick, (i == 4) || (i == 8));
      chk("term_done", done, (i == 8));
    end
    chk("term_count0", count, 16'h0000);
    step();
    chk("term_running_after", running, 1'b0);
    chk("term_done_after", done, 1'b0);
    chk("term_tick_after", tick, 1'b0);
    do_start();
    chk("term_restart_count", count, 16'h0000);
    chk("term_restart_done", done, 1'b0);
    chk("term_restart_running", running, 1'b0);
    step();
    chk("term_restart_done2", done, 1'b0);

    // Pause / resume: running rises at R, done expected at R+23
    do_load(16'h0003);
    do_start();
    chk("pr_running", running, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 4) chk("pr_first_tick", tick, 1'b1);
    end
    chk("pr_count2", count, 16'h0002);
    pause = 1'b1;
    step();                       // R+6
    pause = 1'b0;
    chk("pr_paused_running", running, 1'b0);
    for (int c = 7; c <= 15; c++) begin
      step();
      chk("pr_frozen_count", count, 16'h0002);
      chk("pr_frozen_tick", tick, 1'b0);
    end
    do_start();                   // R+16
    chk("pr_resume_running", running, 1'b1);
    for (int c = 17; c <= 23; c++) begin
      step();
      if (c == 19) chk("pr_count1", count, 16'h0001);
      chk("pr_done", done, (c == 23));
    end
    chk("pr_count0", count, 16'h0000);

    // start + pause together in RUN -> PAUSED
    do_load(16'h0005);
    do_start();
    start = 1'b1; pause = 1'b1;
    step();
    start = 1'b0; pause = 1'b0;
    chk("sp_running", running, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("sp_tick", tick, 1'b0);
    end
    chk("sp_count", count, 16'h0005);
    do_start();
    chk("sp_resume_running", running, 1'b1);

    // Load clamp and abort at the would-be decrement edge
    do_load(16'h0051);
    do_start();
    for (int i = 1; i <= 4; i++) step();
    chk("la_count50", count, 16'h0050);
    chk("la_tick50", tick, 1'b1);
    step(); step(); step();
    do_load(16'h00AF);
    chk("la_count", count, 16'h0099);
    chk("la_running", running, 1'b0);
    chk("la_tick", tick, 1'b0);
    chk("la_done", done, 1'b0);
    for (int i = 0; i < 5; i++) step();
    chk("la_idle_count", count, 16'h0099);
    chk("la_idle_running", running, 1'b0);

    // Reset mid-run at the would-be decrement edge
    do_start();
    chk("rm_running", running, 1'b1);
    step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rm_count", count, 16'h0000);
    chk("rm_running0", running, 1'b0);
    chk("rm_tick", tick, 1'b0);
    chk("rm_done", done, 1'b0);

    // Zero start
    do_load(16'h0000);
    do_start();
    chk("zs_done", done, 1'b1);
    chk("zs_running", running, 1'b0);
    chk("zs_tick", tick, 1'b0);
    step();
    chk("zs_done_pulse", done, 1'b0);
    chk("zs_running2", running, 1'b0);
    do_start();
    chk("zs_restart_done", done, 1'b0);
    chk("zs_restart_running", running, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/countdown_chain_timer.md
Name: countdown_chain_timer

Overview:
- Loadable, cascaded modulo-M down-counter chain; the count-down counterpart of the free-running up-counter chain.
- Each stage decrements only on a borrow from the stage below, which mirrors the terminal-count enable scheme.
- An internal prescaler generates the decrement tick, and a small control FSM handles start/pause/done.
- Used for board countdown timers (BCD digits to HEX displays) and as a loadable event/delay timer.

Parameters:
- STAGE_WIDTH, 4, bits per stage.
- NUM_STAGES, 4, number of cascaded stages; stage 0 is least significant.
- STAGE_MAX, 9, largest value a stage holds (modulus-1); 9 gives BCD.
- PRESCALE, 50000000, clk cycles per decrement tick; must be >=1 (1 = tick every RUN cycle).

Ports:
- clk  in  1  system clock (50 MHz on board); all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- load  in  1  one-cycle strobe: capture load_value.
- load_value  in  STAGE_WIDTH*NUM_STAGES  initial count; stage k occupies bits [k*STAGE_WIDTH +: STAGE_WIDTH].
- start  in  1  begin or resume counting.
- pause  in  1  suspend counting.
- count  out  STAGE_WIDTH*NUM_STAGES  current chain value, registered.
- tick  out  1  one-cycle pulse, registered; high in the cycle count shows a newly decremented value.
- running  out  1  high while FSM is in RUN.
- done  out  1  one-cycle pulse, registered; high in the first cycle count reads all zeros after a countdown.

Behaviour:
- Reset state: count=0, FSM=IDLE, prescaler=PRESCALE-1, tick=0, running=0, done=0.
- FSM states: IDLE, RUN, PAUSED, DONE.
- Priority order: reset > load > pause > start.
- load (any state):
  - Each stage gets min(field, STAGE_MAX); e.g. 0xA clamps to 9.
  - Prescaler reloads to PRESCALE-1; FSM goes to IDLE; tick and done stay 0 that cycle.
- IDLE + start:
  - If count!=0: go to RUN next cycle, prescaler=PRESCALE-1.
  - If count==0: go to DONE; done pulses in the next cycle.
- RUN:
  - Prescaler decrements every cycle.
  - When it is 0, it reloads PRESCALE-1 and a decrement occurs. The first decrement is visible PRESCALE cycles after running rises; the same spacing applies thereafter.
  - Decrement rule: stage 0 always steps. Stage k steps iff stages 0..k-1 are all 0 (borrow chain). A stepping stage at 0 wraps to STAGE_MAX; otherwise it subtracts 1.
  - If a decrement makes count==0: FSM goes to DONE, with done=1 and tick=1 in the same cycle count shows 0.
- pause in RUN: go to PAUSED; prescaler and count are frozen. pause in any other state is ignored.
- start + pause asserted together in RUN: pause wins.
- PAUSED + start (pause low): go to RUN; the prescaler resumes from its frozen value with no reload.
- start in RUN is ignored.
- DONE: count holds 0, done is not re-pulsed, start is ignored. Only load or reset leaves DONE.
- Chain never wraps below 0: the all-zero state is terminal.
- running is a registered decode of state==RUN.
- Reset or load mid-run aborts immediately; no tick or done is produced for the aborted run.

Test Plan (PRESCALE=4, defaults otherwise):
- Reset: assert reset 2 cycles with start=1 held -> count=0x0000, running=0, tick=0, done=0; FSM stays IDLE after release until start.
- Borrow across stages:
  - Stimulus: load 0x0102, pulse start.
  - Required: running=1 next cycle; count steps to 0x0101, 0x0100, 0x0099, 0x0098, each exactly 4 cycles apart; tick pulses 1 cycle with each step.
- Terminal count:
  - Stimulus: load 0x0002, start.
  - Required: count 0x0001, then 0x0000 4 cycles later; done=1 and tick=1 for exactly that cycle; running=0 next cycle.
  - Then pulse start again -> no change; done stays 0.
- Pause/resume:
  - Stimulus: load 0x0003, start; pause 2 cycles after the first tick, hold paused 10 cycles, then start.
  - Required: count frozen at 0x0002 throughout the pause; done occurs exactly 12+10+1 cycles after the original running rise (prescaler not reloaded).
  - Also: start+pause together in RUN -> PAUSED.
- Load clamp and abort:
  - Stimulus: during RUN at count 0x0050, load 0x00AF.
  - Required: count=0x0099 next cycle, running=0, FSM IDLE, no tick/done.
  - Also: reset mid-run -> all outputs 0 next cycle.
- Zero start: load 0x0000, start -> done pulses 1 cycle later; running never asserts; FSM DONE.
